multibyte_add_sequencer: RTL and testbench

//  Sequences one internal 8-bit RippleCarryAdder over NBYTES byte lanes, LSB first, to add

---
 rtl/multibyte_add_sequencer.sv | 120 ++++++++++++
 tb/tb_multibyte_add_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial wide adder: one 8-bit ripple-carry adder stepped over NBYTES lanes.
// Optional ADD_SUB_EN macro adds a 'sub' port for A - B.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  input  logic              cin,
`ifdef ADD_SUB_EN
  input  logic              sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*NBYTES-1:0] sum_out,
  output logic              cout_out,
  output logic              busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;

  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [7:0]    add_s;
  logic          add_co;
  logic          rc;
  logic [W-1:0]  sum_d;
  logic [IW+2:0] sh;
  logic [W-1:0]  b_ld;
  logic          c_ld;

  assign sh     = {idx_q, 3'b000};
  assign a_byte = 8'(a_q >> sh);
  assign b_byte = 8'(b_q >> sh);

  // Ripple chain for the active lane
  always_comb begin
    add_s = '0;
    rc    = carry_q;
    for (int i = 0; i < 8; i++) begin
      add_s[i] = a_byte[i] ^ b_byte[i] ^ rc;
      rc       = (a_byte[i] & b_byte[i]) | (rc & (a_byte[i] ^ b_byte[i]));
    end
    add_co = rc;
  end

  assign sum_d = (sum_q & ~(W'(8'hFF) << sh)) | (W'(add_s) << sh);

`ifdef ADD_SUB_EN
  assign b_ld = sub ? ~b_in : b_in;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b_in;
  assign c_ld = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_in;
            b_q     <= b_ld;
            carry_q <= c_ld;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= add_co;
          if (idx_q == LAST) begin
            cout_q  <= add_co;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = sum_q;
  assign cout_out  = cout_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer (NBYTES=4 and NBYTES=1).
module tb_multibyte_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin;
  logic [31:0] a_in, b_in;
  logic        sub_s;
  logic        in_ready, out_valid, cout_out, busy;
  logic [31:0] sum_out;

  logic        in_valid1, out_ready1, cin1;
  logic [7:0]  a1, b1;
  logic        in_ready1, out_valid1, cout1, busy1;
  logic [7:0]  sum1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multibyte_add_sequencer #(.NBYTES(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef ADD_SUB_EN
    .sub(sub_s),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out), .busy(busy)
  );

  multibyte_add_sequencer #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a1), .b_in(b1), .cin(cin1),
`ifdef ADD_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum_out(sum1), .cout_out(cout1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic s,
                       input logic [31:0] es, input logic ec);
    int lat;
    a_in = a; b_in = b; cin = c; sub_s = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, ".busy"}, busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, lat, 4);
    chk({tag, ".sum"}, sum_out, es);
    chk({tag, ".cout"}, cout_out, ec);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".idle"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0;
    a_in = '0; b_in = '0; sub_s = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    step(); step();
    rst = 1'b0;
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.sum", sum_out, 32'h0);
    chk("rst.cout", cout_out, 1'b0);

    // 1: full carry propagation
    do_op("t1", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1);

    // 2: backpressure in DONE
    a_in = 32'h12345678; b_in = 32'h0F0F0F0F; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4 && !out_valid; i++) step();
    for (int i = 0; i < 3; i++) begin
      chk("t2.valid", out_valid, 1'b1);
      chk("t2.sum", sum_out, 32'h21436588);
      chk("t2.cout", cout_out, 1'b0);
      chk("t2.in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2.idle", in_ready, 1'b1);

    // 3: reset during RUN at idx=2
    a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t3.in_ready", in_ready, 1'b1);
    chk("t3.out_valid", out_valid, 1'b0);
    chk("t3.sum", sum_out, 32'h0);
    chk("t3.cout", cout_out, 1'b0);
    do_op("t3b", 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0);

    // 4: new request while busy is ignored
    a_in = 32'h11111111; b_in = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
    step();
    a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4.in_ready", in_ready, 1'b0);
      step();
    end
    chk("t4.valid", out_valid, 1'b1);
    chk("t4.sum", sum_out, 32'h33333333);
    chk("t4.cout", cout_out, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4.idle", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t4.accept2", busy, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("t4.valid2", out_valid, 1'b1);
    chk("t4.sum2", sum_out, 32'hFFFFFFFF);
    chk("t4.cout2", cout_out, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // extra lane patterns
    do_op("t7", 32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0);
    do_op("t8", 32'hDEADBEEF, 32'h21524110, 1'b1, 1'b0, 32'h0, 1'b1);
    do_op("t9", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // 5: single-lane instance
    a1 = 8'h80; b1 = 8'h80; cin1 = 1'b1; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("t5.run", out_valid1, 1'b0);
    step();
    chk("t5.valid", out_valid1, 1'b1);
    chk("t5.sum", sum1, 8'h01);
    chk("t5.cout", cout1, 1'b1);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("t5.idle", in_ready1, 1'b1);

`ifdef ADD_SUB_EN
    do_op("t6a", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
    do_op("t6b", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
